// File: rtl/lin_pkg.sv
// Shared widths and clamp helper for the two-point linear interpolator.
package lin_pkg;

    localparam int COORD_W = 10;
    localparam int DIFF_W  = COORD_W + 1;
    localparam int PROD_W  = 2 * COORD_W + 2;
    localparam int SUM_W   = 2 * COORD_W + 3;

    // Clamps a signed value into [0, 2^w - 1]; caller slices the low w bits.
    function automatic logic [63:0] sat_u(
        input logic signed [63:0] v,
        input int                 w
    );
        logic signed [63:0] lim;
        lim = (64'sd1 <<< w) - 64'sd1;
        if (v < 64'sd0) begin
            sat_u = 64'd0;
        end else if (v > lim) begin
            sat_u = lim;
        end else begin
            sat_u = v;
        end
    endfunction

endpackage

// File: rtl/lin_sdiv.sv
// Combinational signed divider, unrolled restoring array on magnitudes.
module lin_sdiv #(
    parameter int NW = 22,
    parameter int DW = 11
) (
    input  logic signed [NW-1:0] num,
    input  logic signed [DW-1:0] den,
    output logic signed [NW-1:0] quo
);

    logic [NW-1:0] a_mag;
    logic [DW-1:0] b_mag;
    logic [NW-1:0] q_mag;
    logic [DW:0]   rem;
    logic          neg;
    logic          den_zero;

    always_comb begin
        a_mag    = num[NW-1] ? NW'(-num) : NW'(num);
        b_mag    = den[DW-1] ? DW'(-den) : DW'(den);
        neg      = num[NW-1] ^ den[DW-1];
        den_zero = (den == '0);
    end

    always_comb begin
        rem   = '0;
        q_mag = '0;
        for (int i = NW - 1; i >= 0; i--) begin
            rem = {rem[DW-1:0], a_mag[i]};
            if (rem >= {1'b0, b_mag}) begin
                rem      = rem - {1'b0, b_mag};
                q_mag[i] = 1'b1;
            end
        end
    end

    always_comb begin
        quo = '0;
        if (!den_zero) begin
            quo = neg ? -$signed(q_mag) : $signed(q_mag);
        end
    end

endmodule

// File: rtl/linear_interpolate.sv
// Registered two-point linear interpolator with extrapolation and clamping.
module linear_interpolate
    import lin_pkg::*;
#(
    parameter int WIDTH = COORD_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] x0,
    input  logic [WIDTH-1:0] y0,
    input  logic [WIDTH-1:0] x1,
    input  logic [WIDTH-1:0] y1,
    output logic [WIDTH-1:0] y
);

    localparam int DW = WIDTH + 1;
    localparam int PW = 2 * WIDTH + 2;
    localparam int SW = 2 * WIDTH + 3;

    logic signed [DW-1:0] dx;
    logic signed [DW-1:0] dy;
    logic signed [DW-1:0] den;
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] quo;
    logic signed [SW-1:0] sum;
    logic        [63:0]   clamped;
    logic [WIDTH-1:0]     y_d;
    logic [WIDTH-1:0]     y_q;

    always_comb begin
        dx  = $signed({1'b0, x})  - $signed({1'b0, x0});
        dy  = $signed({1'b0, y1}) - $signed({1'b0, y0});
        den = $signed({1'b0, x1}) - $signed({1'b0, x0});
        // Low PW bits of the product are sign-agnostic once both sides are extended.
        prod = $signed({{(PW-DW){dx[DW-1]}}, dx})
             * $signed({{(PW-DW){dy[DW-1]}}, dy});
    end

    lin_sdiv #(
        .NW (PW),
        .DW (DW)
    ) u_div (
        .num (prod),
        .den (den),
        .quo (quo)
    );

    always_comb begin
        sum = $signed({{(SW-WIDTH){1'b0}}, y0})
            + $signed({{(SW-PW){quo[PW-1]}}, quo});
        clamped = sat_u({{(64-SW){sum[SW-1]}}, sum}, WIDTH);
        y_d = (den == '0) ? y0 : clamped[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q <= '0;
        end else begin
            y_q <= y_d;
        end
    end

    assign y = y_q;

endmodule

// File: tb/tb_linear_interpolate.sv
// Directed bench for linear_interpolate with hand-computed expectations.
module tb_linear_interpolate;

    logic       clk;
    logic       rst;
    logic [9:0] x;
    logic [9:0] x0;
    logic [9:0] y0;
    logic [9:0] x1;
    logic [9:0] y1;
    logic [9:0] y;

    int checks;
    int failures;

    linear_interpolate #(.WIDTH(10)) dut (
        .clk (clk),
        .rst (rst),
        .x   (x),
        .x0  (x0),
        .y0  (y0),
        .x1  (x1),
        .y1  (y1),
        .y   (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [9:0] exp);
        checks++;
        assert (y === exp) else begin
            failures++;
            $error("FAIL %s y=%0d expected=%0d", tag, y, exp);
        end
    endtask

    task automatic seg(input int a0, input int b0, input int a1, input int b1);
        x0 = 10'(a0);
        y0 = 10'(b0);
        x1 = 10'(a1);
        y1 = 10'(b1);
    endtask

    task automatic step(input string tag, input int xv, input int exp);
        x = 10'(xv);
        @(posedge clk);
        #1;
        check(tag, 10'(exp));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst = 1'b1;
        seg(3, 500, 9, 100);
        x = 10'd4;
        @(posedge clk);
        #1;
        check("reset_arbitrary", 10'd0);

        seg(0, 0, 0, 0);
        x   = 10'd0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("release_den0", 10'd0);

        seg(0, 0, 2, 4);
        x = 10'd1;
        #1;
        check("latency_hold", 10'd0);
        @(posedge clk);
        #1;
        check("rise_x1", 10'd2);
        step("rise_x2", 2, 4);

        seg(2, 0, 6, 4);
        step("offset_x4", 4, 2);
        step("offset_x6", 6, 4);

        seg(6, 6, 8, 7);
        step("trunc_x6", 6, 6);
        step("trunc_x7", 7, 6);
        step("trunc_x8", 8, 7);

        seg(0, 10, 3, 0);
        step("decr_negtrunc", 1, 7);

        seg(6, 0, 2, 4);
        step("reversed_x", 4, 2);

        seg(0, 1000, 1, 1023);
        step("sat_high", 10, 1023);

        seg(0, 5, 1, 0);
        step("sat_low", 10, 0);

        seg(5, 77, 5, 200);
        step("degen_x0", 0, 77);
        step("degen_x5", 5, 77);
        step("degen_x1023", 1023, 77);

        seg(0, 0, 2, 4);
        x = 10'd2;
        @(posedge clk);
        #1;
        check("pre_midreset", 10'd4);
        rst = 1'b1;
        x   = 10'd1;
        @(posedge clk);
        #1;
        check("midstream_reset", 10'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_reset_load", 10'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
